aes_enc_ctrl: RTL and testbench
===============================

AES_ENC_CTRL -- requirements
Module: aes_enc_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  plaintext/key offer from requester.
REQ-004 in_ready  output  1  controller can accept a block.
REQ-005 plaintext  input  128  block to encrypt; sampled on in_valid&&in_ready.
REQ-006 key  input  128  AES-128 cipher key; sampled with plaintext.
REQ-007 rnd_state  output  128  registered state driven to the single-round datapath.
REQ-008 rnd_key  output  128  registered round key driven to the round datapath.
REQ-009 rnd_round  output  4  round number driven to the round datapath (1..10).
REQ-010 rnd_nextstate  input  128  round datapath result state (combinational).
REQ-011 rnd_nextkey  input  128  round datapath expanded key (combinational).
REQ-012 out_valid  output  1  ciphertext available.
REQ-013 out_ready  input  1  consumer accepts ciphertext.
REQ-014 ciphertext  output  128  encrypted block; stable while out_valid=1.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, RUN, DONE; encoding from shared package.
REQ-017 IDLE: in_ready=1; on in_valid: rnd_state<=plaintext^key, rnd_key<=key, rnd_round<=1, go RUN.
REQ-018 RUN: in_ready=0; each cycle rnd_state<=rnd_nextstate, rnd_key<=rnd_nextkey, rnd_round<=rnd_round+1.
REQ-019 RUN, rnd_round==FINAL_ROUND (10): capture ciphertext<=rnd_nextstate, go DONE; rnd_round not incremented past 10.
REQ-020 Latency: accept edge = cycle 0; out_valid rises after edge of cycle 10 (11 rising edges from accept, inclusive).
REQ-021 DONE: out_valid=1, ciphertext held; on out_ready go IDLE, out_valid=0 next cycle.
REQ-022 No bypass: a new block is never accepted in the cycle DONE is left; in_ready rises the cycle after handshake-out.
REQ-023 in_valid while busy is ignored; no input is sampled outside IDLE.
REQ-024 out_ready while out_valid=0 has no effect.
REQ-025 ciphertext, rnd_state, rnd_key retain value in IDLE (no clearing on completion).
REQ-026 rnd_round is a 4-bit counter; values 0 and 11..15 never occur after first accept.

Reset
REQ-027 rst_n low forces immediately: state=IDLE, in_ready=1, out_valid=0, busy=0, rnd_state=0, rnd_key=0, rnd_round=0, ciphertext=0.
REQ-028 Reset mid-RUN or mid-DONE aborts the block; no out_valid is produced for it.
REQ-029 First accept is allowed on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package aes_pkg holds FINAL_ROUND=4'ha, FIRST_ROUND=4'h1, FSM state type.
REQ-031 No sub-module; round datapath is instantiated by the parent beside this controller.
REQ-032 Single always block for registers, separate combinational next-state logic.

Verification
REQ-033 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 edges after accept.
REQ-034 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-035 out_ready held 0 for 20 cycles after out_valid -> ciphertext/out_valid stable, in_ready=0 throughout, new in_valid ignored.
REQ-036 in_valid pulsed with a different key during RUN -> result still C.1 ciphertext; second block not started.
REQ-037 rst_n asserted at round 5 -> all outputs zero same cycle, no out_valid; next accept of App.B vector yields correct ciphertext.
REQ-038 Back-to-back: in_valid and out_ready held 1 -> one completion per 12 cycles, both vectors correct in order.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES controller definitions: round bounds and the controller FSM state type.
package aes_pkg;

    // Round numbering driven to the single-round datapath runs FIRST_ROUND..FINAL_ROUND.
    localparam logic [3:0] FIRST_ROUND = 4'h1;
    localparam logic [3:0] FINAL_ROUND = 4'ha;

    // Controller states; the encoding is shared so neighbouring blocks can decode it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

endpackage

// File: rtl/aes_enc_ctrl.sv
// AES-128 encryption controller.
// Sequences one block through an external single-round datapath: loads the
// whitened state and cipher key, iterates rounds 1..10 one per clock, then
// holds the ciphertext until the consumer takes it.
module aes_enc_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] rnd_state,
    output logic [127:0] rnd_key,
    output logic [3:0]   rnd_round,
    input  logic [127:0] rnd_nextstate,
    input  logic [127:0] rnd_nextkey,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    aes_state_e   state;
    aes_state_e   state_nx;
    logic [127:0] rnd_state_nx;
    logic [127:0] rnd_key_nx;
    logic [3:0]   rnd_round_nx;
    logic [127:0] ciphertext_nx;

    // Handshake and status flags decode straight from the state register, so
    // they take their reset values the moment rst_n falls.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Next-state and next-register values for every controller register.
    always_comb begin
        // NOTE: every signal gets a hold value before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_nx      = state;
        rnd_state_nx  = rnd_state;
        rnd_key_nx    = rnd_key;
        rnd_round_nx  = rnd_round;
        ciphertext_nx = ciphertext;

        case (state)
            IDLE: begin
                // Inputs are sampled only here; initial AddRoundKey is done locally.
                if (in_valid) begin
                    rnd_state_nx = plaintext ^ key;
                    rnd_key_nx   = key;
                    rnd_round_nx = FIRST_ROUND;
                    state_nx     = RUN;
                end
            end

            RUN: begin
                rnd_state_nx = rnd_nextstate;
                rnd_key_nx   = rnd_nextkey;
                if (rnd_round == FINAL_ROUND) begin
                    // Round counter parks at the final round.
                    ciphertext_nx = rnd_nextstate;
                    state_nx      = DONE;
                end else begin
                    rnd_round_nx = rnd_round + 4'h1;
                end
            end

            DONE: begin
                // No bypass back to accept: IDLE (and in_ready) follows one cycle later.
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // All controller registers; async reset clears the whole datapath interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rnd_state  <= '0;
            rnd_key    <= '0;
            rnd_round  <= '0;
            ciphertext <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the
            // values present before the edge, independent of statement order.
            state      <= state_nx;
            rnd_state  <= rnd_state_nx;
            rnd_key    <= rnd_key_nx;
            rnd_round  <= rnd_round_nx;
            ciphertext <= ciphertext_nx;
        end
    end

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Self-checking bench for aes_enc_ctrl.
// Supplies a behavioural AES-128 round datapath, a block-level timing model
// compared every cycle, and FIPS-197 literal vectors.
module tb_aes_enc_ctrl;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [127:0] rnd_state;
    logic [127:0] rnd_key;
    logic [3:0]   rnd_round;
    logic [127:0] rnd_nextstate;
    logic [127:0] rnd_nextkey;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    aes_enc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .plaintext     (plaintext),
        .key           (key),
        .rnd_state     (rnd_state),
        .rnd_key       (rnd_key),
        .rnd_round     (rnd_round),
        .rnd_nextstate (rnd_nextstate),
        .rnd_nextkey   (rnd_nextkey),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ciphertext    (ciphertext),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES-128 arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p = x;
        logic [7:0] r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int r);
        logic [7:0] c = 8'h01;
        for (int i = 1; i < r; i++) c = xt(c);
        return c;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // One cipher round: SubBytes, ShiftRows, MixColumns (skipped in the last), AddRoundKey.
    function automatic logic [127:0] round_fn(input logic [127:0] st, input logic [127:0] rk,
                                              input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   s0, s1, s2, s3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = sbox(st[127 - 8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r + 4*c] = a[r + 4*((c + r) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                s0 = b[4*c]; s1 = b[4*c+1]; s2 = b[4*c+2]; s3 = b[4*c+3];
                b[4*c]   = gmul(s0, 8'h02) ^ gmul(s1, 8'h03) ^ s2 ^ s3;
                b[4*c+1] = s0 ^ gmul(s1, 8'h02) ^ gmul(s2, 8'h03) ^ s3;
                b[4*c+2] = s0 ^ s1 ^ gmul(s2, 8'h02) ^ gmul(s3, 8'h03);
                b[4*c+3] = gmul(s0, 8'h03) ^ s1 ^ s2 ^ gmul(s3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = b[i];
        return res ^ rk;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s  = pt ^ k;
        logic [127:0] rk = k;
        for (int r = 1; r <= 10; r++) begin
            rk = key_exp(rk, rcon(r));
            s  = round_fn(s, rk, r == 10);
        end
        return s;
    endfunction

    // Round datapath beside the controller (combinational).
    always_comb begin
        rnd_nextkey   = key_exp(rnd_key, rcon(int'(rnd_round)));
        rnd_nextstate = round_fn(rnd_state, rnd_nextkey, rnd_round == 4'ha);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Block-level model: a block is in flight from its accept edge; its result
    // appears 10 edges after accept and is released by an out_ready edge.
    logic         m_active  = 1'b0;
    int           m_age     = 0;
    int           m_round   = 0;
    logic [127:0] m_ct      = '0;
    logic [127:0] m_last_ct = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  <= 1'b0;
            m_age     <= 0;
            m_round   <= 0;
            m_ct      <= '0;
            m_last_ct <= '0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active <= 1'b1;
                m_age    <= 0;
                m_round  <= 1;
                m_ct     <= aes_ref(plaintext, key);
            end
        end else if (m_age >= 10) begin
            if (out_ready) m_active <= 1'b0;
        end else begin
            m_age   <= m_age + 1;
            m_round <= (m_age + 2 > 10) ? 10 : m_age + 2;
            if (m_age + 1 == 10) m_last_ct <= m_ct;
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clk) begin
        check("in_ready",   in_ready,   !m_active);
        check("out_valid",  out_valid,  m_active && (m_age >= 10));
        check("busy",       busy,       m_active);
        check("rnd_round",  rnd_round,  m_round[3:0]);
        check("ciphertext", ciphertext, m_last_ct);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [127:0] pt, input logic [127:0] k);
        logic ok = 1'b0;
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
        check("accept_timeout", ok, 1'b1);
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_drain_out_valid", out_valid, 1'b0);
        check("post_drain_in_ready",  in_ready,  1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int           e;
        int           n_done;
        int           done_cyc [2];
        logic [127:0] done_ct  [2];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key       = '0;
        repeat (3) tick();

        check("rst_rnd_state",  rnd_state,  128'h0);
        check("rst_rnd_key",    rnd_key,    128'h0);
        check("rst_ciphertext", ciphertext, 128'h0);
        check("rst_in_ready",   in_ready,   1'b1);
        rst_n = 1'b1;
        tick();

        // C.1 vector, with a foreign offer pulsed mid-run.
        offer(C1_PT, C1_KEY);
        check("load_rnd_state", rnd_state, C1_PT ^ C1_KEY);
        check("load_rnd_key",   rnd_key,   C1_KEY);
        check("load_rnd_round", rnd_round, 4'h1);
        e = 0;
        while (!out_valid && e < 40) begin
            if (e == 3) begin
                in_valid  = 1'b1;
                plaintext = B_PT;
                key       = B_KEY;
            end
            if (e == 5) in_valid = 1'b0;
            tick();
            e++;
        end
        in_valid = 1'b0;
        check("c1_latency_edges", e, 10);
        check("c1_ciphertext", ciphertext, C1_CT);
        check("c1_final_round", rnd_round, 4'ha);

        // Stall the consumer for 20 cycles while a new offer is presented.
        in_valid  = 1'b1;
        plaintext = B_PT;
        key       = B_KEY;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_out_valid",  out_valid,  1'b1);
            check("stall_in_ready",   in_ready,   1'b0);
            check("stall_ciphertext", ciphertext, C1_CT);
        end
        in_valid = 1'b0;
        drain();
        check("idle_keeps_ct", ciphertext, C1_CT);

        // Appendix B vector.
        offer(B_PT, B_KEY);
        wait_out(e);
        check("b_latency_edges", e, 10);
        check("b_ciphertext", ciphertext, B_CT);
        drain();

        // Reset at round 5 aborts the block.
        offer(C1_PT, C1_KEY);
        repeat (4) tick();
        check("pre_abort_round", rnd_round, 4'h5);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",   in_ready,   1'b1);
        check("abort_out_valid",  out_valid,  1'b0);
        check("abort_busy",       busy,       1'b0);
        check("abort_rnd_state",  rnd_state,  128'h0);
        check("abort_rnd_key",    rnd_key,    128'h0);
        check("abort_rnd_round",  rnd_round,  4'h0);
        check("abort_ciphertext", ciphertext, 128'h0);
        repeat (2) tick();
        plaintext = B_PT;
        key       = B_KEY;
        in_valid  = 1'b1;
        rst_n     = 1'b1;
        tick();
        in_valid = 1'b0;
        check("first_edge_accept", busy, 1'b1);
        check("first_edge_state",  rnd_state, B_PT ^ B_KEY);
        wait_out(e);
        check("post_rst_latency", e, 10);
        check("post_rst_ct", ciphertext, B_CT);
        drain();

        // Back-to-back with both handshakes held high.
        n_done    = 0;
        out_ready = 1'b1;
        plaintext = C1_PT;
        key       = C1_KEY;
        in_valid  = 1'b1;
        tick();
        plaintext = B_PT;
        key       = B_KEY;
        for (int i = 0; i < 60 && n_done < 2; i++) begin
            if (out_valid) begin
                done_cyc[n_done] = cyc;
                done_ct[n_done]  = ciphertext;
                n_done++;
                if (n_done == 2) in_valid = 1'b0;
            end
            if (n_done < 2) tick();
        end
        in_valid = 1'b0;
        check("b2b_completions", n_done, 2);
        if (n_done == 2) begin
            check("b2b_ct0",    done_ct[0], C1_CT);
            check("b2b_ct1",    done_ct[1], B_CT);
            check("b2b_period", done_cyc[1] - done_cyc[0], 12);
        end
        repeat (3) tick();
        out_ready = 1'b0;
        check("end_idle", busy, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
